// File: rtl/fft_reorder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fft_reorder
//
// Output stage of the 16-point radix-2 FFT core. Samples arrive in bit-reversed
// order, one complex I/Q pair per cycle. Each frame is written into one bank of
// a two-bank ping-pong store at its bit-reversed address. The frame is then
// streamed out in natural bin order (bin 0..N-1) over a valid/ready handshake.
// One frame can be written while the previous one drains.
//
// Optional feature (compile-time macro FFT_REORDER_MAG_EN):
//   Adds output port out_mag = out_i^2 + out_q^2. It is registered alongside
//   the output sample, so it is aligned with out_valid.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   in_i, in_q    signed FFT result, bit-reversed arrival order
//   in_valid      in_i/in_q carry a sample this cycle
//   in_ready      the current write bank can accept a sample
//   out_i, out_q  signed sample in natural bin order
//   out_idx       bin index of the current output sample
//   out_valid     out_* hold a valid sample
//   out_ready     consumer accepts the sample this cycle
//   out_last      high with out_valid on bin N-1
//   overflow      sticky flag: a sample arrived while in_ready was low
//   clr_overflow  synchronous clear of overflow
//   out_mag       (FFT_REORDER_MAG_EN only) unsigned squared magnitude
// -----------------------------------------------------------------------------
module fft_reorder #(
    parameter int SAMPLE_WORD_LENGTH = 8,
    parameter int FFT_POINTS         = 16,
    parameter int IDX_WIDTH          = $clog2(FFT_POINTS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic signed [SAMPLE_WORD_LENGTH-1:0] in_i,
    input  logic signed [SAMPLE_WORD_LENGTH-1:0] in_q,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic signed [SAMPLE_WORD_LENGTH-1:0] out_i,
    output logic signed [SAMPLE_WORD_LENGTH-1:0] out_q,
    output logic        [IDX_WIDTH-1:0]          out_idx,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_last,
    output logic                                 overflow,
    input  logic                                 clr_overflow
`ifdef FFT_REORDER_MAG_EN
    ,
    output logic        [2*SAMPLE_WORD_LENGTH:0] out_mag
`endif
);

    localparam int W  = SAMPLE_WORD_LENGTH;
    localparam int N  = FFT_POINTS;
    localparam int AW = IDX_WIDTH + 1;   // {bank, index}
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_e;

    // Reverse the bit order of a bin index.
    function automatic logic [IDX_WIDTH-1:0] bitrev(input logic [IDX_WIDTH-1:0] x);
        logic [IDX_WIDTH-1:0] r;
        for (int b = 0; b < IDX_WIDTH; b++) begin
            r[b] = x[IDX_WIDTH-1-b];
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [2*W-1:0]       mem_q [2*N];      // {bank, addr} -> {I, Q}

    logic                 wr_bank_q;
    logic [IDX_WIDTH-1:0] wr_cnt_q;
    logic [1:0]           bank_full_q, bank_full_d;
    logic                 overflow_q,  overflow_d;

    rd_state_e            state_q;
    logic                 rd_bank_q;
    logic [IDX_WIDTH-1:0] rd_cnt_q;
    logic                 out_valid_q;
    logic signed [W-1:0]  out_i_q, out_q_q;

    // -------------------------------------------------------------------------
    // Write side
    // -------------------------------------------------------------------------
    logic wr_acc;
    logic wr_drop;
    logic wr_frame_done;

    assign in_ready      = !bank_full_q[wr_bank_q];
    assign wr_acc        = in_valid && in_ready;
    assign wr_drop       = in_valid && !in_ready;
    assign wr_frame_done = wr_acc && (wr_cnt_q == LAST_IDX);

    // -------------------------------------------------------------------------
    // Read side: next sample to load into the output register
    // -------------------------------------------------------------------------
    logic                 rd_hs;
    logic                 rd_frame_done;
    logic                 load_en;
    logic                 load_bank;
    logic [IDX_WIDTH-1:0] load_idx;
    logic [2*W-1:0]       load_word;
    logic signed [W-1:0]  out_i_d, out_q_d;

    assign rd_hs         = out_valid_q && out_ready;
    assign rd_frame_done = (state_q == STREAM) && rd_hs && (rd_cnt_q == LAST_IDX);

    always_comb begin
        load_en   = 1'b0;
        load_bank = rd_bank_q;
        load_idx  = '0;
        case (state_q)
            IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    load_en = 1'b1;
                end
            end
            STREAM: begin
                if (rd_hs) begin
                    if (rd_cnt_q != LAST_IDX) begin
                        load_en  = 1'b1;
                        load_idx = rd_cnt_q + IDX_WIDTH'(1);
                    end else if (bank_full_q[!rd_bank_q]) begin
                        // Next frame already complete: start it with no bubble.
                        load_en   = 1'b1;
                        load_bank = !rd_bank_q;
                    end
                end
            end
            default: ;
        endcase
    end

    assign load_word = mem_q[{load_bank, load_idx}];
    assign out_i_d   = load_word[2*W-1:W];
    assign out_q_d   = load_word[W-1:0];

`ifdef FFT_REORDER_MAG_EN
    // Squares computed one bit wider than 2*W: the largest sum, reached at
    // I = Q = -2^(W-1), is 2^(2W-1) and still reads as a positive value.
    logic signed [2*W:0] ext_i, ext_q;
    logic signed [2*W:0] sq_i, sq_q;
    logic        [2*W:0] mag_d, mag_q;

    assign ext_i = {{(W+1){out_i_d[W-1]}}, out_i_d};
    assign ext_q = {{(W+1){out_q_d[W-1]}}, out_q_d};
    assign sq_i  = ext_i * ext_i;
    assign sq_q  = ext_q * ext_q;
    assign mag_d = sq_i + sq_q;
`endif

    // -------------------------------------------------------------------------
    // Shared bank flags: the writer sets the bank it completes, the reader
    // clears the bank it finishes. They never name the same bank on one edge.
    // -------------------------------------------------------------------------
    always_comb begin
        bank_full_d = bank_full_q;
        if (rd_frame_done) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
        if (wr_frame_done) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    assign overflow_d = wr_drop || (overflow_q && !clr_overflow);

    // -------------------------------------------------------------------------
    // Writer registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            bank_full_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            bank_full_q <= bank_full_d;
            overflow_q  <= overflow_d;
            if (wr_acc) begin
                wr_cnt_q <= wr_cnt_q + IDX_WIDTH'(1);
                if (wr_cnt_q == LAST_IDX) begin
                    wr_bank_q <= !wr_bank_q;
                end
            end
        end
    end

    // Sample store: no reset, contents are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[{wr_bank_q, bitrev(wr_cnt_q)}] <= {in_i, in_q};
        end
    end

    // -------------------------------------------------------------------------
    // Reader state machine with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
`ifdef FFT_REORDER_MAG_EN
            mag_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_en) begin
                        state_q     <= STREAM;
                        out_valid_q <= 1'b1;
                        rd_cnt_q    <= '0;
                    end
                end
                STREAM: begin
                    if (rd_hs) begin
                        if (!rd_frame_done) begin
                            rd_cnt_q <= rd_cnt_q + IDX_WIDTH'(1);
                        end else begin
                            rd_bank_q <= !rd_bank_q;
                            rd_cnt_q  <= '0;
                            if (!load_en) begin
                                out_valid_q <= 1'b0;
                                state_q     <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase

            // Output data only changes on a load, so it holds under back-pressure.
            if (load_en) begin
                out_i_q <= out_i_d;
                out_q_q <= out_q_d;
`ifdef FFT_REORDER_MAG_EN
                mag_q   <= mag_d;
`endif
            end
        end
    end

    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_idx   = rd_cnt_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_valid_q && (rd_cnt_q == LAST_IDX);
    assign overflow  = overflow_q;
`ifdef FFT_REORDER_MAG_EN
    assign out_mag   = mag_q;
`endif

endmodule

// File: tb/tb_fft_reorder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fft_reorder
//
// Bench for fft_reorder. The reference model treats the block as a frame
// reorderer: every 16 accepted samples form a frame whose k-th sample belongs
// to bin bitrev(k); completed frames are queued in natural bin order, and the
// write side is ready while fewer than two completed frames are still waiting
// to drain. Outputs are collected on each handshake and compared per test.
// -----------------------------------------------------------------------------
module tb_fft_reorder;

    localparam int W = 8;
    localparam int N = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [W-1:0] in_i, in_q;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] out_i, out_q;
    logic [3:0]          out_idx;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic                overflow;
    logic                clr_overflow;
`ifdef FFT_REORDER_MAG_EN
    logic [2*W:0]        out_mag;
`endif

    always #5 clk = ~clk;

    fft_reorder #(
        .SAMPLE_WORD_LENGTH(W),
        .FFT_POINTS        (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_i        (in_i),
        .in_q        (in_q),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_i       (out_i),
        .out_q       (out_q),
        .out_idx     (out_idx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
`ifdef FFT_REORDER_MAG_EN
        ,
        .out_mag     (out_mag)
`endif
    );

    typedef struct {
        int idx;
        int i;
        int q;
    } samp_t;

    typedef struct {
        int idx;
        int i;
        int q;
        bit last;
        int cyc;
        int mag;
    } obs_t;

    samp_t exp_q[$];
    obs_t  got_q[$];

    // Reference model state
    int nat_i[N];
    int nat_q[N];
    int wr_k;
    int pending;
    int consumed;
    bit ovf_m;
    int cyc;
    int last_acc_cyc;

    int tests_run;
    int tests_failed;

    function automatic int bitrev(input int x);
        int r;
        r = 0;
        for (int b = 0; b < 4; b++) begin
            r = r * 2 + ((x >> b) & 1);
        end
        return r;
    endfunction

    // Advance one clock: observe at the falling edge, update the model at the
    // rising edge, return 1 time unit later so the caller can drive inputs.
    task automatic cycle();
        bit   acc, drop, hs;
        obs_t o;
        @(negedge clk);
        acc  = in_valid && (pending < 2);
        drop = in_valid && !(pending < 2);
        hs   = out_valid && out_ready;
        if (hs) begin
            o.idx  = int'(out_idx);
            o.i    = int'(out_i);
            o.q    = int'(out_q);
            o.last = out_last;
            o.cyc  = cyc;
`ifdef FFT_REORDER_MAG_EN
            o.mag  = int'(out_mag);
`else
            o.mag  = 0;
`endif
            got_q.push_back(o);
        end
        @(posedge clk);
        cyc++;
        if (acc) begin
            nat_i[bitrev(wr_k)] = int'(in_i);
            nat_q[bitrev(wr_k)] = int'(in_q);
            wr_k++;
            last_acc_cyc = cyc;
            if (wr_k == N) begin
                for (int b = 0; b < N; b++) begin
                    exp_q.push_back('{b, nat_i[b], nat_q[b]});
                end
                wr_k = 0;
                pending++;
            end
        end
        if (hs) begin
            consumed++;
            if (consumed % N == 0) pending--;
        end
        if (drop) ovf_m = 1'b1;
        else if (clr_overflow) ovf_m = 1'b0;
        #1;
    endtask

    task automatic model_reset();
        wr_k     = 0;
        pending  = 0;
        consumed = 0;
        ovf_m    = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
        in_i = '0; in_q = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        tests_run++; if (out_i !== 8'sd0) begin tests_failed++; $display("FAIL reset out_i: got %0d want 0", out_i); end
        tests_run++; if (out_q !== 8'sd0) begin tests_failed++; $display("FAIL reset out_q: got %0d want 0", out_q); end
        tests_run++; if (out_idx !== 4'd0) begin tests_failed++; $display("FAIL reset out_idx: got %0d want 0", out_idx); end
        tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset out_last: got %b want 0", out_last); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset overflow: got %b want 0", overflow); end
`ifdef FFT_REORDER_MAG_EN
        tests_run++; if (out_mag !== '0) begin tests_failed++; $display("FAIL reset out_mag: got %0d want 0", out_mag); end
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        obs_t  g;
        samp_t e;
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_i = 8'(bitrev(k));
            in_q = 8'(-bitrev(k));
            cycle();
        end
        in_valid = 1'b0;
        repeat (24) cycle();
        tests_run++;
        if (got_q.size() != N) begin
            tests_failed++;
            $display("FAIL single_frame count: got %0d outputs want %0d", got_q.size(), N);
        end else begin
            tests_run++;
            if (got_q[0].cyc !== last_acc_cyc + 1) begin
                tests_failed++;
                $display("FAIL single_frame latency: first output cycle %0d want %0d", got_q[0].cyc, last_acc_cyc + 1);
            end
            tests_run++;
            if (got_q[N-1].cyc !== got_q[0].cyc + N - 1) begin
                tests_failed++;
                $display("FAIL single_frame contiguous: last output cycle %0d want %0d", got_q[N-1].cyc, got_q[0].cyc + N - 1);
            end
            tests_run++;
            if (got_q[N-1].i !== 15 || got_q[N-1].q !== -15) begin
                tests_failed++;
                $display("FAIL single_frame bin15: got i=%0d q=%0d want i=15 q=-15", got_q[N-1].i, got_q[N-1].q);
            end
        end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL single_frame extra: got idx=%0d i=%0d, want no output", g.idx, g.i);
            end else begin
                e = exp_q.pop_front();
                if (g.idx !== e.idx || g.i !== e.i || g.q !== e.q || g.last !== (e.idx == N-1)) begin
                    tests_failed++;
                    $display("FAIL single_frame data: got idx=%0d i=%0d q=%0d last=%0d want idx=%0d i=%0d q=%0d last=%0d",
                             g.idx, g.i, g.q, g.last, e.idx, e.i, e.q, e.idx == N-1);
                end
            end
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL single_frame missing: %0d outputs outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_backpressure();
        obs_t  g;
        samp_t e;
        int    vi[N];
        int    vq[N];
        bit    bp_done;
        logic signed [W-1:0] r;
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            r = 8'($urandom); vi[k] = int'(r);
            r = 8'($urandom); vq[k] = int'(r);
            in_valid = 1'b1;
            in_i = 8'(vi[k]);
            in_q = 8'(vq[k]);
            cycle();
        end
        in_valid = 1'b0;
        bp_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!bp_done && out_valid && out_idx == 4'd5) begin
                out_ready = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    cycle();
                    tests_run++;
                    if (out_valid !== 1'b1 || out_idx !== 4'd5 || int'(out_i) !== vi[bitrev(5)] || int'(out_q) !== vq[bitrev(5)]) begin
                        tests_failed++;
                        $display("FAIL backpressure hold: got valid=%b idx=%0d i=%0d q=%0d want valid=1 idx=5 i=%0d q=%0d",
                                 out_valid, out_idx, out_i, out_q, vi[bitrev(5)], vq[bitrev(5)]);
                    end
                end
                out_ready = 1'b1;
                bp_done = 1'b1;
            end
            cycle();
        end
        tests_run++;
        if (!bp_done) begin
            tests_failed++;
            $display("FAIL backpressure reach: out_idx 5 never seen, want it within 40 cycles");
        end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL backpressure extra: got idx=%0d i=%0d, want no output", g.idx, g.i);
            end else begin
                e = exp_q.pop_front();
                if (g.idx !== e.idx || g.i !== e.i || g.q !== e.q || g.last !== (e.idx == N-1)) begin
                    tests_failed++;
                    $display("FAIL backpressure data: got idx=%0d i=%0d q=%0d want idx=%0d i=%0d q=%0d",
                             g.idx, g.i, g.q, e.idx, e.i, e.q);
                end
            end
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL backpressure missing: %0d outputs outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_ping_pong();
        obs_t  g;
        samp_t e;
        bit    rdy_ok;
        out_ready = 1'b1;
        rdy_ok = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < N; k++) begin
                in_valid = 1'b1;
                in_i = 8'(16 * f + bitrev(k));
                in_q = 8'($urandom);
                if (in_ready !== 1'b1) rdy_ok = 1'b0;
                cycle();
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (rdy_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL ping_pong in_ready: dropped during writes, want 1 throughout");
        end
        repeat (40) cycle();
        tests_run++;
        if (got_q.size() != 2 * N) begin
            tests_failed++;
            $display("FAIL ping_pong count: got %0d outputs want %0d", got_q.size(), 2 * N);
        end else begin
            tests_run++;
            if (got_q[2*N-1].cyc !== got_q[0].cyc + 2 * N - 1) begin
                tests_failed++;
                $display("FAIL ping_pong bubble: last output cycle %0d want %0d", got_q[2*N-1].cyc, got_q[0].cyc + 2 * N - 1);
            end
        end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL ping_pong extra: got idx=%0d i=%0d, want no output", g.idx, g.i);
            end else begin
                e = exp_q.pop_front();
                if (g.idx !== e.idx || g.i !== e.i || g.q !== e.q || g.last !== (e.idx == N-1)) begin
                    tests_failed++;
                    $display("FAIL ping_pong data: got idx=%0d i=%0d q=%0d want idx=%0d i=%0d q=%0d",
                             g.idx, g.i, g.q, e.idx, e.i, e.q);
                end
            end
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL ping_pong missing: %0d outputs outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_overflow();
        obs_t  g;
        samp_t e;
        out_ready = 1'b0;
        for (int j = 0; j < 3 * N; j++) begin
            in_valid = 1'b1;
            in_i = 8'($urandom);
            in_q = 8'($urandom);
            cycle();
            if (j == 2 * N - 1) begin
                tests_run++;
                if (in_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL overflow in_ready: got %b after 32 accepts want 0", in_ready);
                end
                tests_run++;
                if (overflow !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL overflow early: got %b before any drop want 0", overflow);
                end
            end
            if (j == 2 * N) begin
                tests_run++;
                if (overflow !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL overflow set: got %b after first drop want 1", overflow);
                end
            end
        end
        clr_overflow = 1'b1;
        cycle();
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow set_wins: got %b with drop and clear together want 1", overflow);
        end
        in_valid = 1'b0;
        cycle();
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow clear: got %b want 0", overflow);
        end
        clr_overflow = 1'b0;
        out_ready = 1'b1;
        repeat (40) cycle();
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL overflow extra: got idx=%0d i=%0d, want no output", g.idx, g.i);
            end else begin
                e = exp_q.pop_front();
                if (g.idx !== e.idx || g.i !== e.i || g.q !== e.q || g.last !== (e.idx == N-1)) begin
                    tests_failed++;
                    $display("FAIL overflow data: got idx=%0d i=%0d q=%0d want idx=%0d i=%0d q=%0d",
                             g.idx, g.i, g.q, e.idx, e.i, e.q);
                end
            end
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL overflow missing: %0d outputs outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_random();
        obs_t  g;
        samp_t e;
        int    guard;
        for (int c = 0; c < 400; c++) begin
            in_valid     = ($urandom % 4) != 0;
            in_i         = 8'($urandom);
            in_q         = 8'($urandom);
            out_ready    = ($urandom % 3) != 0;
            clr_overflow = ($urandom % 16) == 0;
            tests_run++;
            if (in_ready !== (pending < 2)) begin
                tests_failed++;
                $display("FAIL random in_ready: got %b want %0d (cycle %0d)", in_ready, pending < 2, cyc);
            end
            cycle();
            tests_run++;
            if (overflow !== ovf_m) begin
                tests_failed++;
                $display("FAIL random overflow: got %b want %b (cycle %0d)", overflow, ovf_m, cyc);
            end
        end
        // Complete any partial frame so later tests start on a frame boundary.
        clr_overflow = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (wr_k != 0 && guard < 64) begin
            in_valid = 1'b1;
            in_i = 8'($urandom);
            in_q = 8'($urandom);
            cycle();
            guard++;
        end
        in_valid = 1'b0;
        clr_overflow = 1'b1;
        cycle();
        clr_overflow = 1'b0;
        repeat (48) cycle();
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL random extra: got idx=%0d i=%0d, want no output", g.idx, g.i);
            end else begin
                e = exp_q.pop_front();
                if (g.idx !== e.idx || g.i !== e.i || g.q !== e.q || g.last !== (e.idx == N-1)) begin
                    tests_failed++;
                    $display("FAIL random data: got idx=%0d i=%0d q=%0d want idx=%0d i=%0d q=%0d",
                             g.idx, g.i, g.q, e.idx, e.i, e.q);
                end
            end
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL random missing: %0d outputs outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

`ifdef FFT_REORDER_MAG_EN
    task automatic test_mag();
        obs_t  g;
        samp_t e;
        int    bi[N];
        int    bq[N];
        logic signed [W-1:0] r;
        for (int b = 0; b < N; b++) begin
            r = 8'($urandom); bi[b] = int'(r);
            r = 8'($urandom); bq[b] = int'(r);
        end
        bi[3] = 3;    bq[3] = -4;
        bi[9] = -128; bq[9] = -128;
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_i = 8'(bi[bitrev(k)]);
            in_q = 8'(bq[bitrev(k)]);
            cycle();
        end
        in_valid = 1'b0;
        repeat (24) cycle();
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            tests_run++;
            if (g.mag !== g.i * g.i + g.q * g.q) begin
                tests_failed++;
                $display("FAIL mag value: idx=%0d got %0d want %0d", g.idx, g.mag, g.i * g.i + g.q * g.q);
            end
            if (g.idx == 3) begin
                tests_run++;
                if (g.mag !== 25) begin tests_failed++; $display("FAIL mag bin3: got %0d want 25", g.mag); end
            end
            if (g.idx == 9) begin
                tests_run++;
                if (g.mag !== 32768) begin tests_failed++; $display("FAIL mag bin9: got %0d want 32768", g.mag); end
            end
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL mag extra: got idx=%0d, want no output", g.idx);
            end else begin
                e = exp_q.pop_front();
                if (g.idx !== e.idx || g.i !== e.i || g.q !== e.q) begin
                    tests_failed++;
                    $display("FAIL mag data: got idx=%0d i=%0d q=%0d want idx=%0d i=%0d q=%0d",
                             g.idx, g.i, g.q, e.idx, e.i, e.q);
                end
            end
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL mag missing: %0d outputs outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        obs_t  g;
        samp_t e;
        // One complete frame waiting (out_valid high) plus 7 samples of the next.
        out_ready = 1'b0;
        for (int k = 0; k < N + 7; k++) begin
            in_valid = 1'b1;
            in_i = 8'($urandom);
            in_q = 8'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #2;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid out_valid: got %b want 0", out_valid);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid in_ready: got %b want 1", in_ready);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_i = 8'($urandom);
            in_q = 8'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        repeat (24) cycle();
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL reset_mid extra: got idx=%0d i=%0d, want no output", g.idx, g.i);
            end else begin
                e = exp_q.pop_front();
                if (g.idx !== e.idx || g.i !== e.i || g.q !== e.q || g.last !== (e.idx == N-1)) begin
                    tests_failed++;
                    $display("FAIL reset_mid data: got idx=%0d i=%0d q=%0d want idx=%0d i=%0d q=%0d",
                             g.idx, g.i, g.q, e.idx, e.i, e.q);
                end
            end
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_mid missing: %0d outputs outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        last_acc_cyc = 0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_ping_pong();
        test_overflow();
        test_random();
`ifdef FFT_REORDER_MAG_EN
        test_mag();
`endif
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
